// File: rtl/ins_fetch_ctrl_pkg.sv
// rtl/ins_fetch_ctrl_pkg.sv - shared fetch FSM states and default reset PC
package ins_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ins_fetch_fifo.sv
// rtl/ins_fetch_fifo.sv - synchronous {pc, instruction} FIFO with flush and count
module ins_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    // Push on full is legal only together with a pop, which frees the head slot.
    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != DEPTH_C) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ins_fetch_ctrl.sv
// rtl/ins_fetch_ctrl.sv - PC owner and fetch sequencer between InsMEM and decode
module ins_fetch_ctrl
    import ins_fetch_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    PC_STEP    = 4,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic [ADDR_WIDTH-1:0]         ins_addr,
    input  logic [DATA_WIDTH-1:0]         ins_data,
    output logic                          if_valid,
    input  logic                          if_ready,
    output logic [ADDR_WIDTH-1:0]         if_pc,
    output logic [DATA_WIDTH-1:0]         if_ins,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          misalign_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  misalign_q, misalign_d;
    logic                  pop;
    logic                  push;
    logic [FW-1:0]         fifo_rdata;

    assign pop  = if_valid & if_ready;
    assign push = (state_q == ST_RUN) & fetch_en & ~redirect_valid
                & ((fifo_count != DEPTH_C) | pop);

    // Redirect leaves the FSM alone; only fetch_en moves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_HOLD;
            ST_HOLD: if (fetch_en)  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (push) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // InsMEM is combinational, so ins_data belongs to pc_q in the same cycle.
    ins_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({pc_q, ins_data}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign ins_addr      = pc_q;
    assign if_valid      = (fifo_count != '0);
    assign {if_pc, if_ins} = fifo_rdata;
    assign misalign_err  = misalign_q;

endmodule
